// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encodings and default timer width for the debouncer
package debounce_pkg;
  localparam int DEFAULT_N = 19;
  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] ONE   = 2'b11;
  localparam logic [1:0] WAIT0 = 2'b10;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  // shift the raw level through two flops to settle metastability
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/debounce_fsm.sv
// debounce_fsm: switch debouncer, accepts a level held for 2^N+1 synchronised samples
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic iCLK,
  input  logic iRESET_N,
  input  logic iSW,
  output logic oDB_LEVEL,
  output logic oBUSY
);
  logic         sw_sync;
  logic [1:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;

  sync_2ff u_sync (
    .clk_i (iCLK),
    .rst_ni(iRESET_N),
    .d_i   (iSW),
    .q_o   (sw_sync)
  );

  // state and stability timer registers
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: a disagreeing sample aborts before the timer expiry is considered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: if (sw_sync) begin
        state_d = WAIT1;
        cnt_d   = '1;
      end
      WAIT1: if (!sw_sync) state_d = ZERO;
        else if (cnt_q == '0) state_d = ONE;
        else cnt_d = cnt_q - 1'b1;
      ONE: if (!sw_sync) begin
        state_d = WAIT0;
        cnt_d   = '1;
      end
      WAIT0: if (sw_sync) state_d = ONE;
        else if (cnt_q == '0) state_d = ZERO;
        else cnt_d = cnt_q - 1'b1;
      default: state_d = ZERO;
    endcase
  end

  // encoding puts the level in bit 1 and makes both WAIT states odd-parity
  assign oDB_LEVEL = state_q[1];
  assign oBUSY     = ^state_q;
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: scoreboarded random and directed checks of the debouncer against a run-length model
module tb_debounce_fsm;
  localparam int N = 3;
  localparam int ACCEPT = (1 << N) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic db_level, busy;
  int n_tests = 0;
  int n_fail = 0;
  int ticks = 0;
  logic prev_lvl = 1'b0;

  bit m_d1 = 1'b0, m_d2 = 1'b0, m_lvl = 1'b0;
  int m_run = 0;
  logic [1:0] exp_q[$];

  debounce_fsm #(.N(N)) dut (
    .iCLK     (clk),
    .iRESET_N (rst_n),
    .iSW      (sw),
    .oDB_LEVEL(db_level),
    .oBUSY    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: the debounced level flips once the synchronised input has
  // disagreed with it for ACCEPT consecutive samples; busy means a run is open
  always @(negedge rst_n) begin
    m_d1 = 1'b0; m_d2 = 1'b0; m_lvl = 1'b0; m_run = 0;
  end

  always @(posedge clk) begin
    bit s;
    if (!rst_n) exp_q.push_back(2'b00);
    else begin
      s = m_d2;
      m_d2 = m_d1;
      m_d1 = sw;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == ACCEPT) begin
          m_lvl = ~m_lvl;
          m_run = 0;
        end
      end else m_run = 0;
      exp_q.push_back({m_lvl, m_run != 0});
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("model_level", db_level, e[1]);
      chk("model_busy", busy, e[0]);
    end
  end

  // downstream dual-edge tick detector
  always @(posedge clk) prev_lvl <= db_level;
  always @(negedge clk) if (db_level != prev_lvl) ticks++;

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      #1 sw = v;
    end
  endtask

  // caller has just set the new level; e0 is the next rising edge
  task automatic check_edges(input string nm, input bit tgt);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_level"}, db_level, (k >= 10) ? tgt : !tgt);
      chk({nm, "_busy"}, busy, (k >= 2 && k < 10) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sw = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_level", db_level, 0);
    chk("reset_busy", busy, 0);
    #1 rst_n = 1'b1;
    check_edges("press", 1'b1);

    @(negedge clk);
    #1 sw = 1'b0;
    check_edges("release", 1'b0);

    drive(1'b0, 4);
    drive(1'b1, 8);
    #0 sw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reject8_busy", busy, (k < 2) ? 1 : 0);
      chk("reject8_level", db_level, 0);
    end
    drive(1'b0, 4);
    drive(1'b1, 9);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 sw = 1'b0;
    end
    chk("accept9_level", db_level, 1);
    drive(1'b0, 14);
    chk("accept9_back", db_level, 0);

    ticks = 0;
    for (int i = 0; i < 42; i++) drive(((i / 3) % 2) == 0, 1);
    @(negedge clk);
    #1 sw = 1'b1;
    check_edges("bounce", 1'b1);
    chk("bounce_ticks", ticks, 1);

    drive(1'b0, 14);
    chk("pre_rst_level", db_level, 0);
    drive(1'b1, 5);
    @(negedge clk);
    chk("mid_wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", db_level, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    check_edges("post_rst", 1'b1);

    drive(1'b0, 14);
    ticks = 0;
    for (int i = 0; i < 8; i++) drive(i % 2 == 0, $urandom_range(1, 4));
    drive(1'b1, 14);
    for (int i = 0; i < 8; i++) drive(i % 2 == 1, $urandom_range(1, 4));
    drive(1'b0, 14);
    chk("chain_ticks", ticks, 2);
    chk("chain_level", db_level, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        #1 rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
